// File: rtl/if_id_rx.sv
// -----------------------------------------------------------------------------
// if_id_rx : ID-side receiver for the 64-bit IF/ID pipeline bus.
//
// Buffers fetched words in a 2-entry skid buffer (head + skid) and splits the
// head word into decode fields. It detects load-use hazards against the
// instruction in EX and presents a bubble while one is active. A branch flush
// from EX discards everything buffered.
//
// Handshake: a word moves across an interface on a clock edge where both
// valid and ready are high. valid must not depend on ready. Here in_ready
// depends only on the buffer state. out_valid depends on the state, the
// hazard compare and flush, and never on out_ready.
//
// Optional feature: define IF_ID_RX_STATS_EN to add the saturating 16-bit
// counters stall_cnt and flush_cnt.
//
// Ports:
//   clock, reset             posedge clock, synchronous active-high reset
//   IF_ID_in[63:0]           {PC+4, instruction} from the fetch register
//   in_valid / in_ready      fetch-side handshake
//   flush                    branch/jump taken in EX, drop all entries
//   ex_mem_read, ex_rt       load in EX and its destination register
//   out_valid / out_ready    handshake towards ID/EX
//   pc_plus4, instr          head entry
//   opcode..funct, imm_sext  decode fields of the head instruction
//   hazard_stall             load-use stall active this cycle
//   state_dbg[1:0]           buffer state (0 EMPTY, 1 ONE, 2 TWO)
//   stall_cnt, flush_cnt     statistics (IF_ID_RX_STATS_EN only)
// -----------------------------------------------------------------------------
module if_id_rx #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [PC_W+INSTR_W-1:0]  IF_ID_in,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     flush,
   input  logic                     ex_mem_read,
   input  logic [4:0]               ex_rt,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PC_W-1:0]          pc_plus4,
   output logic [INSTR_W-1:0]       instr,
   output logic [5:0]               opcode,
   output logic [4:0]               rs,
   output logic [4:0]               rt,
   output logic [4:0]               rd,
   output logic [4:0]               shamt,
   output logic [5:0]               funct,
   output logic [31:0]              imm_sext,
   output logic                     hazard_stall,
`ifdef IF_ID_RX_STATS_EN
   output logic [15:0]              stall_cnt,
   output logic [15:0]              flush_cnt,
`endif
   output logic [1:0]               state_dbg
);

   localparam int BUS_W = PC_W + INSTR_W;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t             state;
   logic [BUS_W-1:0]   head;
   logic [BUS_W-1:0]   skid;
   logic               push;
   logic               pop;

   assign state_dbg = state;

   // The head register is zeroed whenever it is empty, so the fields need no
   // extra masking to read 0 in EMPTY.
   assign pc_plus4 = head[BUS_W-1:INSTR_W];
   assign instr    = head[INSTR_W-1:0];
   assign opcode   = instr[31:26];
   assign rs       = instr[25:21];
   assign rt       = instr[20:16];
   assign rd       = instr[15:11];
   assign shamt    = instr[10:6];
   assign funct    = instr[5:0];
   assign imm_sext = {{16{instr[15]}}, instr[15:0]};

   assign in_ready = (state != TWO);

   // The rt compare is deliberately not qualified by opcode. This can stall
   // on false positives, but it never misses a real dependency.
   assign hazard_stall = (state != EMPTY) && ex_mem_read && (ex_rt != 5'd0) &&
                         ((ex_rt == rs) || (ex_rt == rt));

   assign out_valid = (state != EMPTY) && !hazard_stall && !flush;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         // A flush drops any word pushed in the same cycle.
         state <= EMPTY;
         head  <= '0;
         skid  <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  head  <= IF_ID_in;
                  state <= ONE;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  skid  <= IF_ID_in;
                  state <= TWO;
               end else if (push && pop) begin
                  head  <= IF_ID_in;
               end else if (pop) begin
                  head  <= '0;
                  state <= EMPTY;
               end
            end
            TWO: begin
               if (pop) begin
                  head  <= skid;
                  skid  <= '0;
                  state <= ONE;
               end
            end
            default: begin
               state <= EMPTY;
               head  <= '0;
               skid  <= '0;
            end
         endcase
      end
   end

`ifdef IF_ID_RX_STATS_EN
   // The counters survive a flush. Only reset clears them.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (hazard_stall && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
         if (flush && (state != EMPTY) && (flush_cnt != 16'hFFFF))
            flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

endmodule
